// File: rtl/regfile_writeback_unit.sv
// In-order writeback queue feeding the register-file write port. Loads wait for
// in-order memory responses; a busy scoreboard exposes pending destinations.
module regfile_writeback_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iss_valid,
  output logic        iss_ready,
  input  logic [4:0]  iss_rd,
  input  logic        iss_is_load,
  input  logic [31:0] iss_data,
  input  logic [2:0]  iss_funct3,
  input  logic [1:0]  iss_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        RegWrite,
  output logic [4:0]  wr,
  output logic [31:0] wd,
  output logic [31:0] busy,
  output logic        err_spurious
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [4:0]       rd_q_r   [DEPTH];
  logic [31:0]      data_q_r [DEPTH];
  logic [2:0]       f3_q_r   [DEPTH];
  logic [1:0]       alo_q_r  [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] done_r;
  logic [DEPTH-1:0] load_r;
  logic [AW-1:0]    head_r;
  logic [AW-1:0]    tail_r;
  logic [AW:0]      count_r;

  logic             push_s;
  logic             pop_s;
  logic             resp_hit_s;
  logic [AW-1:0]    resp_idx_s;
  logic [31:0]      busy_s;

  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  addr_lo);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (addr_lo)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    half_v = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'd0:    res_v = {{24{byte_v[7]}}, byte_v};
      3'd1:    res_v = {{16{half_v[15]}}, half_v};
      3'd4:    res_v = {24'd0, byte_v};
      3'd5:    res_v = {16'd0, half_v};
      default: res_v = word;
    endcase
    return res_v;
  endfunction

  assign iss_ready = (count_r < FULL_C);
  assign push_s    = iss_valid && iss_ready;
  assign pop_s     = valid_r[head_r] && done_r[head_r];
  assign busy      = busy_s;

  // Oldest outstanding load, searched in ring order from the head; the slot
  // being pushed this cycle is not yet valid, so it can never be matched.
  always_comb begin
    resp_hit_s = 1'b0;
    resp_idx_s = head_r;
    for (int k = 0; k < DEPTH; k++) begin
      if (!resp_hit_s && valid_r[head_r + AW'(k)] && load_r[head_r + AW'(k)] &&
          !done_r[head_r + AW'(k)]) begin
        resp_hit_s = 1'b1;
        resp_idx_s = head_r + AW'(k);
      end else begin
        resp_hit_s = resp_hit_s;
      end
    end
  end

  // Scoreboard: every queued destination plus the one being written right now.
  always_comb begin
    busy_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_r[i]) begin
        busy_s[rd_q_r[i]] = 1'b1;
      end else begin
        busy_s = busy_s;
      end
    end
    if (RegWrite) begin
      busy_s[wr] = 1'b1;
    end else begin
      busy_s = busy_s;
    end
    busy_s[0] = 1'b0;
  end

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      done_r  <= '0;
      load_r  <= '0;
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q_r[i]   <= 5'd0;
        data_q_r[i] <= 32'd0;
        f3_q_r[i]   <= 3'd0;
        alo_q_r[i]  <= 2'd0;
      end
    end else begin
      if (push_s) begin
        rd_q_r[tail_r]   <= iss_rd;
        data_q_r[tail_r] <= iss_data;
        f3_q_r[tail_r]   <= iss_funct3;
        alo_q_r[tail_r]  <= iss_addr_lo;
        load_r[tail_r]   <= iss_is_load;
        done_r[tail_r]   <= !iss_is_load;
        valid_r[tail_r]  <= 1'b1;
        tail_r           <= tail_r + AW'(1);
      end
      if (mem_rvalid && resp_hit_s) begin
        data_q_r[resp_idx_s] <= extend_load(mem_rdata, f3_q_r[resp_idx_s], alo_q_r[resp_idx_s]);
        done_r[resp_idx_s]   <= 1'b1;
      end
      if (pop_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered write port; wr/wd hold their last value between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite <= 1'b0;
      wr       <= 5'd0;
      wd       <= 32'd0;
    end else if (pop_s) begin
      RegWrite <= (rd_q_r[head_r] != 5'd0);
      wr       <= rd_q_r[head_r];
      wd       <= data_q_r[head_r];
    end else begin
      RegWrite <= 1'b0;
    end
  end

  // Sticky flag for a response arriving with no load waiting for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_spurious <= 1'b0;
    end else if (mem_rvalid && !resp_hit_s) begin
      err_spurious <= 1'b1;
    end else begin
      err_spurious <= err_spurious;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Self-checking bench for regfile_writeback_unit: extension table, directed
// ordering/full/reset sequences and random traffic against a queue-based model.
module tb_regfile_writeback_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic        iss_ready;
  logic [4:0]  iss_rd;
  logic        iss_is_load;
  logic [31:0] iss_data;
  logic [2:0]  iss_funct3;
  logic [1:0]  iss_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        RegWrite;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic [31:0] busy;
  logic        err_spurious;

  regfile_writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
    .iss_is_load(iss_is_load), .iss_data(iss_data), .iss_funct3(iss_funct3),
    .iss_addr_lo(iss_addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .RegWrite(RegWrite), .wr(wr), .wd(wd), .busy(busy), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        is_load;
    logic [31:0] data;
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic        done;
  } ent_t;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [31:0] rdata;
    logic [31:0] exp_wd;
  } vec_t;

  ent_t        mq[$];
  logic        m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  logic        m_err;
  int          n_tests = 0;
  int          n_fail  = 0;
  vec_t        vecs[13];

  function automatic logic [31:0] ext_ref(logic [31:0] w, logic [2:0] f3, logic [1:0] a);
    int unsigned ai, b, h;
    ai = a;
    b  = (w >> (8 * ai)) & 32'hFF;
    h  = (w >> (16 * (ai / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = 32'd0;
    foreach (mq[i]) b[mq[i].rd] = 1'b1;
    if (m_rw) b[m_wr] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  task automatic check_model();
    chk("RegWrite", {31'd0, RegWrite}, {31'd0, m_rw});
    chk("wr", {27'd0, wr}, {27'd0, m_wr});
    chk("wd", wd, m_wd);
    chk("busy", busy, model_busy());
    chk("iss_ready", {31'd0, iss_ready}, (mq.size() < DEPTH) ? 32'd1 : 32'd0);
    chk("err_spurious", {31'd0, err_spurious}, {31'd0, m_err});
  endtask

  // One clock: the model steps on the same pre-edge inputs the DUT samples.
  task automatic cycle();
    bit   acc, pop, found;
    int   idx;
    ent_t e;
    acc   = iss_valid && (mq.size() < DEPTH);
    pop   = (mq.size() > 0) && mq[0].done;
    found = 0;
    idx   = 0;
    for (int i = 0; i < mq.size(); i++)
      if (!found && mq[i].is_load && !mq[i].done) begin found = 1; idx = i; end
    @(posedge clk);
    if (mem_rvalid) begin
      if (found) begin
        e = mq[idx];
        e.data = ext_ref(mem_rdata, e.f3, e.alo);
        e.done = 1'b1;
        mq[idx] = e;
      end else begin
        m_err = 1'b1;
      end
    end
    if (pop) begin
      e = mq.pop_front();
      m_rw = (e.rd != 5'd0);
      m_wr = e.rd;
      m_wd = e.data;
    end else begin
      m_rw = 1'b0;
    end
    if (acc) begin
      e = '{rd: iss_rd, is_load: iss_is_load, data: iss_data, f3: iss_funct3,
            alo: iss_addr_lo, done: !iss_is_load};
      mq.push_back(e);
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic issue(input logic v, input logic [4:0] rd, input logic ld,
                       input logic [31:0] data, input logic [2:0] f3, input logic [1:0] alo);
    iss_valid = v; iss_rd = rd; iss_is_load = ld; iss_data = data;
    iss_funct3 = f3; iss_addr_lo = alo;
  endtask

  task automatic idle();
    issue(1'b0, 5'd0, 1'b0, 32'd0, 3'd0, 2'd0);
    mem_rvalid = 1'b0;
  endtask

  function automatic int outstanding_loads();
    int n;
    n = 0;
    foreach (mq[i]) if (mq[i].is_load && !mq[i].done) n++;
    return n;
  endfunction

  initial begin
    vecs[0]  = '{3'd0, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80};
    vecs[1]  = '{3'd5, 2'd2, 32'h80FF_0000, 32'h0000_80FF};
    vecs[2]  = '{3'd1, 2'd2, 32'h80FF_0000, 32'hFFFF_80FF};
    vecs[3]  = '{3'd4, 2'd3, 32'h80FF_0000, 32'h0000_0080};
    vecs[4]  = '{3'd0, 2'd0, 32'h1234_A57F, 32'h0000_007F};
    vecs[5]  = '{3'd0, 2'd1, 32'h1234_A57F, 32'hFFFF_FFA5};
    vecs[6]  = '{3'd1, 2'd3, 32'h7ABC_1234, 32'h0000_7ABC};
    vecs[7]  = '{3'd5, 2'd1, 32'h7ABC_1234, 32'h0000_1234};
    vecs[8]  = '{3'd2, 2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[9]  = '{3'd3, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[10] = '{3'd7, 2'd1, 32'h0102_0304, 32'h0102_0304};
    vecs[11] = '{3'd4, 2'd2, 32'h00FE_0000, 32'h0000_00FE};
    vecs[12] = '{3'd1, 2'd0, 32'h0000_8001, 32'hFFFF_8001};

    rst_n = 1'b0;
    idle();
    mem_rdata = 32'd0;
    m_rw = 1'b0; m_wr = 5'd0; m_wd = 32'd0; m_err = 1'b0;
    #3;
    chk("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("rst_wr", {27'd0, wr}, 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_err", {31'd0, err_spurious}, 32'd0);
    chk("rst_ready", {31'd0, iss_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU result reaches the write port two cycles after the handshake.
    issue(1'b1, 5'd5, 1'b0, 32'h1234, 3'd0, 2'd0);
    cycle();
    idle();
    chk("t1_busy5_n1", {31'd0, busy[5]}, 32'd1);
    chk("t1_rw_n1", {31'd0, RegWrite}, 32'd0);
    cycle();
    chk("t1_rw_n2", {31'd0, RegWrite}, 32'd1);
    chk("t1_wr", {27'd0, wr}, 32'd5);
    chk("t1_wd", wd, 32'h1234);
    chk("t1_busy5_n2", {31'd0, busy[5]}, 32'd1);
    cycle();
    chk("t1_busy5_n3", {31'd0, busy[5]}, 32'd0);

    // Load alignment/extension table.
    foreach (vecs[i]) begin
      issue(1'b1, 5'd3, 1'b1, 32'hFFFF_FFFF, vecs[i].f3, vecs[i].alo);
      cycle();
      idle();
      mem_rvalid = 1'b1;
      mem_rdata  = vecs[i].rdata;
      cycle();
      mem_rvalid = 1'b0;
      cycle();
      chk($sformatf("ext%0d_rw", i), {31'd0, RegWrite}, 32'd1);
      chk($sformatf("ext%0d_wd", i), wd, vecs[i].exp_wd);
      cycle();
    end

    // A later ALU result must wait behind an older pending load.
    issue(1'b1, 5'd1, 1'b1, 32'd0, 3'd2, 2'd0);
    cycle();
    issue(1'b1, 5'd2, 1'b0, 32'd9, 3'd0, 2'd0);
    cycle();
    idle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t3_hold_rw", {31'd0, RegWrite}, 32'd0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0011;
    cycle();
    mem_rvalid = 1'b0;
    chk("t3_m1_rw", {31'd0, RegWrite}, 32'd0);
    cycle();
    chk("t3_first_wr", {27'd0, wr}, 32'd1);
    chk("t3_first_wd", wd, 32'h11);
    cycle();
    chk("t3_second_rw", {31'd0, RegWrite}, 32'd1);
    chk("t3_second_wr", {27'd0, wr}, 32'd2);
    chk("t3_second_wd", wd, 32'd9);
    cycle();

    // Fill the queue behind a stalled load, then drain one write per cycle.
    issue(1'b1, 5'd10, 1'b1, 32'd0, 3'd2, 2'd0);
    cycle();
    for (int k = 11; k <= 13; k++) begin
      issue(1'b1, 5'(k), 1'b0, 32'(k * 16), 3'd0, 2'd0);
      cycle();
    end
    chk("t4_full_ready", {31'd0, iss_ready}, 32'd0);
    issue(1'b1, 5'd14, 1'b0, 32'hEE, 3'd0, 2'd0);
    cycle();
    cycle();
    chk("t4_held_ready", {31'd0, iss_ready}, 32'd0);
    idle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55;
    cycle();
    mem_rvalid = 1'b0;
    for (int k = 10; k <= 13; k++) begin
      cycle();
      chk("t4_drain_rw", {31'd0, RegWrite}, 32'd1);
      chk("t4_drain_wr", {27'd0, wr}, 32'(k));
    end
    cycle();

    // rd=0 never writes nor shows busy; response with nothing pending is sticky error.
    issue(1'b1, 5'd0, 1'b0, 32'h77, 3'd0, 2'd0);
    cycle();
    idle();
    chk("t5_busy", busy, 32'd0);
    cycle();
    chk("t5_rw", {31'd0, RegWrite}, 32'd0);
    cycle();
    mem_rvalid = 1'b1;
    cycle();
    mem_rvalid = 1'b0;
    chk("t5_err", {31'd0, err_spurious}, 32'd1);
    cycle();
    cycle();
    chk("t5_err_sticky", {31'd0, err_spurious}, 32'd1);

    // Asynchronous reset with three loads pending.
    issue(1'b1, 5'd9, 1'b0, 32'hABCD, 3'd0, 2'd0);
    cycle();
    for (int k = 4; k <= 6; k++) begin
      issue(1'b1, 5'(k), 1'b1, 32'd0, 3'd2, 2'd0);
      cycle();
    end
    idle();
    chk("t6_pre_wr", {27'd0, wr}, 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rw", {31'd0, RegWrite}, 32'd0);
    chk("t6_wr", {27'd0, wr}, 32'd0);
    chk("t6_wd", wd, 32'd0);
    chk("t6_busy", busy, 32'd0);
    chk("t6_err", {31'd0, err_spurious}, 32'd0);
    mq.delete();
    m_rw = 1'b0; m_wr = 5'd0; m_wd = 32'd0; m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1;
    cycle();
    mem_rvalid = 1'b0;
    chk("t6_late_err", {31'd0, err_spurious}, 32'd1);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      issue($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      if (outstanding_loads() > 0) mem_rvalid = ($urandom_range(0, 9) < 4);
      else                         mem_rvalid = ($urandom_range(0, 99) < 3);
      mem_rdata = $urandom;
      cycle();
    end
    idle();
    for (int n = 0; n < 20; n++) begin
      mem_rvalid = (outstanding_loads() > 0);
      mem_rdata  = $urandom;
      cycle();
    end
    idle();
    cycle();
    chk("final_empty_ready", {31'd0, iss_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
